fetch_unit: RTL and testbench

//  Instruction fetch stage: generates the PC, fetches instructions over the ibus

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction bus request/ack handshake between fetch unit and memory
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata,
        output err
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC generation, ibus fetch, output buffer
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall_decode,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    fetch_unit_if.master ibus,
    output logic         bubble_o,
    output logic [31:0]  pc_o,
    output logic [31:0]  inst_o,
    output logic         fault_o
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          fetch_en;
    logic          pending;
    logic [31:0]   req_addr;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_inst  [BUF_DEPTH];
    logic          buf_fault [BUF_DEPTH];

    logic          pop;
    logic          issue;
    logic          acc;
    logic          push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_n;
        end
    end

    // A new request is only raised when not already waiting on one; the pop term
    // lets a full buffer keep streaming when decode consumes the head this cycle.
    always_comb begin
        state_n   = state;
        pop       = !stall_decode && (count != '0) && !redirect;
        issue     = fetch_en && !pending && (state == ST_RUN) && !redirect &&
                    ((count < CW'(BUF_DEPTH)) || pop);
        ibus.req  = pending || issue;
        ibus.addr = pending ? req_addr : fetch_pc;
        acc       = ibus.ack && ibus.req;
        push      = acc && (state == ST_RUN) && !redirect;

        case (state)
            ST_RUN: begin
                if (redirect) begin
                    state_n = (pending && !acc) ? ST_FLUSH : ST_RUN;
                end else if (push && ibus.err) begin
                    state_n = ST_HALT;
                end
            end
            ST_FLUSH: begin
                if (acc) begin
                    state_n = ST_RUN;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    // fetch_pc doubles as the saved redirect target while a stale response is flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en <= 1'b0;
            pending  <= 1'b0;
            req_addr <= RESET_ADDR;
            fetch_pc <= RESET_ADDR;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            fetch_en <= 1'b1;
            if (acc) begin
                pending <= 1'b0;
            end else if (issue) begin
                pending <= 1'b1;
            end
            if (issue) begin
                req_addr <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= ibus.addr;
            buf_inst[wr_ptr]  <= ibus.err ? 32'h0 : ibus.rdata;
            buf_fault[wr_ptr] <= ibus.err;
        end
    end

    always_comb begin
        bubble_o = (count == '0) || redirect;
        pc_o     = bubble_o ? 32'h0 : buf_pc[rd_ptr];
        inst_o   = bubble_o ? 32'h0 : buf_inst[rd_ptr];
        fault_o  = bubble_o ? 1'b0  : buf_fault[rd_ptr];
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_decode;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        bubble_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fault_o;

    fetch_unit_if ibus();

    fetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .BUF_DEPTH  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_decode (stall_decode),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ibus         (ibus),
        .bubble_o     (bubble_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .fault_o      (fault_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        int          lat;
        int          n;
        logic        use_err;
        logic [31:0] err_pc;
        logic        rand_stall;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          fails = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    logic        use_err = 1'b0;
    logic [31:0] err_pc = 32'h0;
    logic        rand_stall = 1'b0;
    logic        force_stall = 1'b0;
    logic        popped = 1'b0;
    logic [31:0] popped_pc = 32'hDEAD_BEEF;
    logic        acked = 1'b0;
    logic [31:0] acked_addr = 32'hDEAD_BEEF;
    logic        last_req = 1'b0;
    logic [31:0] last_addr = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [31:0] start, input int n, input logic do_err,
                            input logic [31:0] epc);
        logic [31:0] pc;
        exp_t e;
        pc = start & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            e.pc = pc;
            if (do_err && pc == epc) begin
                e.inst  = 32'h0;
                e.fault = 1'b1;
                sb.push_back(e);
                break;
            end
            e.inst  = word_of(pc);
            e.fault = 1'b0;
            sb.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    task automatic step(input logic redir, input logic [31:0] rpc);
        exp_t e;
        logic hold;
        @(negedge clk);
        redirect     = redir;
        redirect_pc  = rpc;
        stall_decode = force_stall || (sb.size() == 0) ||
                       (rand_stall && $urandom_range(0, 2) == 0);
        #1;
        hold = last_req && !acked;
        if (hold) begin
            check("req_held", {31'h0, ibus.req}, 32'h1);
            check("addr_held", ibus.addr, last_addr);
        end
        acked = 1'b0;
        if (ibus.req) begin
            if (wait_cnt >= lat) begin
                ibus.ack   = 1'b1;
                ibus.rdata = word_of(ibus.addr);
                ibus.err   = use_err && (ibus.addr == err_pc);
                wait_cnt   = 0;
                acked      = 1'b1;
                acked_addr = ibus.addr;
            end else begin
                ibus.ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            ibus.ack = 1'b0;
            wait_cnt = 0;
        end
        last_req  = ibus.req;
        last_addr = ibus.addr;
        #1;
        popped = 1'b0;
        if (redir) begin
            check("bubble_on_redirect", {31'h0, bubble_o}, 32'h1);
        end
        if (bubble_o) begin
            check("bubble_fields", pc_o | inst_o | {31'h0, fault_o}, 32'h0);
        end else if (!stall_decode) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pop: got pc %h expected none", pc_o);
            end else begin
                e = sb.pop_front();
                check("pop_pc", pc_o, e.pc);
                check("pop_inst", inst_o, e.inst);
                check("pop_fault", {31'h0, fault_o}, {31'h0, e.fault});
                popped    = 1'b1;
                popped_pc = pc_o;
            end
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 400) begin
            step(1'b0, 32'h0);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d entries left expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n        = 1'b0;
        stall_decode = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        ibus.ack     = 1'b0;
        ibus.rdata   = 32'h0;
        ibus.err     = 1'b0;

        vecs[0] = '{target: 32'h0000_0100, lat: 2, n: 6,  use_err: 1'b0, err_pc: 32'h0,  rand_stall: 1'b1};
        vecs[1] = '{target: 32'hFFFF_FFF7, lat: 1, n: 5,  use_err: 1'b0, err_pc: 32'h0,  rand_stall: 1'b0};
        vecs[2] = '{target: 32'h0000_0010, lat: 0, n: 16, use_err: 1'b1, err_pc: 32'h20, rand_stall: 1'b0};
        vecs[3] = '{target: 32'h0000_0040, lat: 3, n: 4,  use_err: 1'b0, err_pc: 32'h0,  rand_stall: 1'b0};
        vecs[4] = '{target: 32'h0000_0203, lat: 0, n: 8,  use_err: 1'b0, err_pc: 32'h0,  rand_stall: 1'b1};

        #12;
        check("reset_req", {31'h0, ibus.req}, 32'h0);
        check("reset_bubble", {31'h0, bubble_o}, 32'h1);
        check("reset_pc", pc_o, 32'h0);
        check("reset_inst", inst_o, 32'h0);
        check("reset_fault", {31'h0, fault_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // startup with 0-cycle acks: one instruction per cycle
        lat = 0;
        push_run(32'h0, 8, 1'b0, 32'h0);
        k = 0;
        while (!popped && k < 10) begin
            step(1'b0, 32'h0);
            k++;
        end
        check("first_pop_seen", {31'h0, popped}, 32'h1);
        check("first_pop_pc", popped_pc, 32'h0);
        step(1'b0, 32'h0);
        check("consec_pop1", {31'h0, popped}, 32'h1);
        check("consec_pc1", popped_pc, 32'h4);
        step(1'b0, 32'h0);
        check("consec_pop2", {31'h0, popped}, 32'h1);
        check("consec_pc2", popped_pc, 32'h8);

        // decode stall fills the buffer and stops requesting
        force_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            check("stall_pc_hold", pc_o, sb[0].pc);
            check("stall_no_bubble", {31'h0, bubble_o}, 32'h0);
        end
        check("stall_req_low", {31'h0, ibus.req}, 32'h0);
        force_stall = 1'b0;
        drain("drain_stall");

        // redirect while a request is outstanding: stale response discarded
        lat = 4;
        step(1'b1, 32'h10);
        step(1'b0, 32'h0);
        check("flush_req", {31'h0, ibus.req}, 32'h1);
        check("flush_req_addr", ibus.addr, 32'h10);
        push_run(32'h100, 3, 1'b0, 32'h0);
        step(1'b1, 32'h100);
        k = 0;
        while (!acked && k < 10) begin
            step(1'b0, 32'h0);
            k++;
        end
        check("flush_acked", {31'h0, acked}, 32'h1);
        check("flush_ack_addr", acked_addr, 32'h10);
        k = 0;
        do begin
            step(1'b0, 32'h0);
            k++;
        end while (!ibus.req && k < 10);
        check("flush_next_addr", ibus.addr, 32'h100);
        drain("drain_flush");

        // table of redirect targets, latencies, wrap and fault cases
        foreach (vecs[i]) begin
            lat        = vecs[i].lat;
            use_err    = vecs[i].use_err;
            err_pc     = vecs[i].err_pc;
            rand_stall = vecs[i].rand_stall;
            push_run(vecs[i].target, vecs[i].n, vecs[i].use_err, vecs[i].err_pc);
            step(1'b1, vecs[i].target);
            drain($sformatf("drain_vec%0d", i));
            if (vecs[i].use_err) begin
                for (int j = 0; j < 8; j++) begin
                    step(1'b0, 32'h0);
                    check("halt_no_req", {31'h0, ibus.req}, 32'h0);
                end
            end
            rand_stall = 1'b0;
            use_err    = 1'b0;
        end

        // asynchronous reset in the middle of an outstanding request
        lat = 5;
        step(1'b1, 32'h300);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        check("pre_reset_req", {31'h0, ibus.req}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_req", {31'h0, ibus.req}, 32'h0);
        check("async_reset_bubble", {31'h0, bubble_o}, 32'h1);
        check("async_reset_pc", pc_o, 32'h0);
        ibus.ack = 1'b0;
        sb.delete();
        last_req = 1'b0;
        acked    = 1'b0;
        wait_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        lat   = 0;
        push_run(32'h0, 2, 1'b0, 32'h0);
        k = 0;
        do begin
            step(1'b0, 32'h0);
            k++;
        end while (!ibus.req && k < 10);
        check("post_reset_addr", ibus.addr, 32'h0);
        drain("drain_post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
